// File: rtl/fetch_control.sv
// Instruction fetch sequencer: steps IDLE -> FETCH -> EXEC until a halt opcode retires,
// and latches a sticky fault if memory fails to answer within TIMEOUT fetch cycles.
module fetch_control #(
    parameter int         PC_WIDTH = 16,
    parameter int         TIMEOUT  = 255,
    parameter logic [7:0] HALT_OP  = 8'hFF
) (
    input  logic                clk_i,
    input  logic                reset_i,
    input  logic                start_i,
    input  logic [PC_WIDTH-1:0] start_pc_i,
    output logic                mem_req_o,
    output logic [PC_WIDTH-1:0] mem_addr_o,
    input  logic                mem_ack_i,
    input  logic [31:0]         mem_rdata_i,
    input  logic                jump_en_i,
    input  logic [PC_WIDTH-1:0] jump_addr_i,
    output logic [31:0]         instr0_o,
    output logic [3:0]          current_state_o,
    output logic [PC_WIDTH-1:0] pc_o,
    output logic                halted_o,
    output logic                fault_o
);

    localparam int CNT_BITS = $clog2(TIMEOUT + 1);
    localparam int WAIT_W   = (CNT_BITS > 8) ? CNT_BITS : 8;

    typedef enum logic [3:0] {
        IDLE  = 4'd0,
        FETCH = 4'd1,
        EXEC  = 4'd2,
        FAULT = 4'd15
    } state_e;

    state_e              state_q;
    logic                mem_req_q;
    logic [PC_WIDTH-1:0] mem_addr_q;
    logic [31:0]         instr0_q;
    logic [PC_WIDTH-1:0] pc_q;
    logic [PC_WIDTH-1:0] pc_d;
    logic                halted_q;
    logic                fault_q;
    logic [WAIT_W-1:0]   wait_q;

    // Successor address for a non-halting instruction; the increment wraps naturally.
    always_comb begin
        pc_d = pc_q + PC_WIDTH'(1);
        if (jump_en_i) begin
            pc_d = jump_addr_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q    <= IDLE;
            mem_req_q  <= 1'b0;
            mem_addr_q <= '0;
            instr0_q   <= '0;
            pc_q       <= '0;
            halted_q   <= 1'b0;
            fault_q    <= 1'b0;
            wait_q     <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start_i) begin
                        pc_q       <= start_pc_i;
                        mem_addr_q <= start_pc_i;
                        mem_req_q  <= 1'b1;
                        halted_q   <= 1'b0;
                        wait_q     <= '0;
                        state_q    <= FETCH;
                    end
                end
                FETCH: begin
                    // An ack in the last permitted cycle still wins over the timeout.
                    if (mem_ack_i) begin
                        instr0_q  <= mem_rdata_i;
                        mem_req_q <= 1'b0;
                        wait_q    <= '0;
                        state_q   <= EXEC;
                    end else if (wait_q == WAIT_W'(TIMEOUT - 1)) begin
                        mem_req_q <= 1'b0;
                        fault_q   <= 1'b1;
                        state_q   <= FAULT;
                    end else begin
                        wait_q <= wait_q + WAIT_W'(1);
                    end
                end
                EXEC: begin
                    if (instr0_q[31:24] == HALT_OP) begin
                        halted_q <= 1'b1;
                        state_q  <= IDLE;
                    end else begin
                        pc_q       <= pc_d;
                        mem_addr_q <= pc_d;
                        mem_req_q  <= 1'b1;
                        state_q    <= FETCH;
                    end
                end
                FAULT: begin
                    fault_q   <= 1'b1;
                    mem_req_q <= 1'b0;
                end
                default: begin
                    state_q   <= IDLE;
                    mem_req_q <= 1'b0;
                end
            endcase
        end
    end

    assign mem_req_o       = mem_req_q;
    assign mem_addr_o      = mem_addr_q;
    assign instr0_o        = instr0_q;
    assign current_state_o = state_q;
    assign pc_o            = pc_q;
    assign halted_o        = halted_q;
    assign fault_o         = fault_q;

endmodule

// File: tb/tb_fetch_control.sv
// Randomized scoreboard bench for fetch_control: a program-walk model predicts the
// retired instruction stream, fetch latencies and final halt address.
module tb_fetch_control;

    localparam int MAX_STEP = 10;

    typedef struct {
        logic [15:0] pc;
        logic [31:0] word;
    } retire_t;

    logic        clk;
    logic        reset;
    logic        start;
    logic [15:0] startPc;
    logic        memReq;
    logic [15:0] memAddr;
    logic        memAck;
    logic [31:0] memRdata;
    logic        jumpEn;
    logic [15:0] jumpAddr;
    logic [31:0] instr0;
    logic [3:0]  curState;
    logic [15:0] pcOut;
    logic        halted;
    logic        fault;

    int checks   = 0;
    int failures = 0;

    logic [31:0] mem [logic [15:0]];
    retire_t     expQ[$];
    logic [16:0] jumpQ[$];
    int          delayQ[$];
    int          expBusy;
    logic [15:0] expLastPc;

    bit          autoDrive = 0;
    bit          monEn     = 0;
    int          ackMode   = 0;
    bit          launchReq = 0;
    logic [15:0] launchPc  = '0;

    fetch_control dut (
        .clk_i          (clk),
        .reset_i        (reset),
        .start_i        (start),
        .start_pc_i     (startPc),
        .mem_req_o      (memReq),
        .mem_addr_o     (memAddr),
        .mem_ack_i      (memAck),
        .mem_rdata_i    (memRdata),
        .jump_en_i      (jumpEn),
        .jump_addr_i    (jumpAddr),
        .instr0_o       (instr0),
        .current_state_o(curState),
        .pc_o           (pcOut),
        .halted_o       (halted),
        .fault_o        (fault)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Walk the program the way the processor should: each address yields one word,
    // halt ends the run, otherwise the planned branch decides the next address.
    task automatic buildModel(input logic [15:0] entry, input int jumpPct, input int fixedDelay,
                              input bit keepMem, input bit firstJump, input logic [15:0] firstTarget);
        logic [15:0] addr;
        logic [15:0] target;
        logic        taken;
        int          d;
        if (!keepMem) mem.delete();
        expQ.delete();
        jumpQ.delete();
        delayQ.delete();
        expBusy = 0;
        addr    = entry;
        for (int s = 0; s < 64; s++) begin
            if (!mem.exists(addr)) begin
                if (s >= MAX_STEP || $urandom_range(0, 5) == 0)
                    mem[addr] = {8'hFF, 24'($urandom)};
                else
                    mem[addr] = {8'($urandom_range(0, 254)), 24'($urandom)};
            end
            d = (fixedDelay >= 0) ? fixedDelay : int'($urandom_range(0, 3));
            delayQ.push_back(d);
            expBusy += d + 2;
            expQ.push_back('{pc: addr, word: mem[addr]});
            expLastPc = addr;
            if (mem[addr][31:24] == 8'hFF) break;
            if (s == 0 && firstJump) begin
                taken  = 1'b1;
                target = firstTarget;
            end else if (s >= MAX_STEP) begin
                taken = 1'b1;
                do target = 16'($urandom); while (mem.exists(target));
            end else begin
                taken  = ($urandom_range(0, 99) < jumpPct);
                target = 16'($urandom);
            end
            jumpQ.push_back({taken, target});
            addr = taken ? target : 16'((32'(addr) + 1) % 65536);
        end
    endtask

    task automatic launch(input logic [15:0] entry);
        @(posedge clk);
        launchPc  = entry;
        launchReq = 1'b1;
    endtask

    task automatic doReset();
        @(negedge clk);
        reset     = 1'b1;
        launchReq = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic applyStimulus(input logic [15:0] entry, input int jumpPct, input int fixedDelay,
                                 input bit keepMem, input bit firstJump, input logic [15:0] firstTarget);
        int busy;
        bit seen;
        buildModel(entry, jumpPct, fixedDelay, keepMem, firstJump, firstTarget);
        monEn   = 1;
        ackMode = 0;
        launch(entry);
        busy = 0;
        seen = 0;
        for (int c = 0; c < 20000; c++) begin
            @(negedge clk);
            if (curState != 4'd0) begin
                busy++;
                seen = 1;
            end else if (seen) begin
                break;
            end
        end
        checkOutput("busy_cycles", busy, expBusy);
        checkOutput("halted_after_run", {31'd0, halted}, 32'd1);
        checkOutput("halt_pc", {16'd0, pcOut}, {16'd0, expLastPc});
        checkOutput("no_fault_after_run", {31'd0, fault}, 32'd0);
        checkOutput("all_retired", expQ.size(), 0);
        checkOutput("req_low_idle", {31'd0, memReq}, 32'd0);
    endtask

    task automatic waitForState(input logic [3:0] target, input int bound);
        int c;
        for (c = 0; c < bound; c++) begin
            @(negedge clk);
            if (curState == target) break;
        end
        if (c == bound) checkOutput("wait_state_timeout", {28'd0, curState}, {28'd0, target});
    endtask

    // Input driver: honours planned branches in EXEC and sprays ignored noise elsewhere.
    initial begin
        start    = 1'b0;
        startPc  = '0;
        jumpEn   = 1'b0;
        jumpAddr = '0;
        forever begin
            @(negedge clk);
            if (autoDrive) begin
                jumpEn   = $urandom_range(0, 1) == 1;
                jumpAddr = 16'($urandom);
                startPc  = 16'($urandom);
                start    = ($urandom_range(0, 3) == 0);
                if (curState == 4'd0) begin
                    start = launchReq;
                    if (launchReq) begin
                        startPc   = launchPc;
                        launchReq = 1'b0;
                    end
                end else if (curState == 4'd2 && jumpQ.size() > 0) begin
                    {jumpEn, jumpAddr} = jumpQ.pop_front();
                end
            end
        end
    end

    // Memory responder: model-timed acks during FETCH, random junk acks elsewhere.
    initial begin
        bit inFetch = 0;
        int cnt     = 0;
        int curDly  = 0;
        memAck   = 1'b0;
        memRdata = '0;
        forever begin
            @(negedge clk);
            if (ackMode == 0) begin
                if (memReq && curState == 4'd1) begin
                    if (!inFetch) begin
                        inFetch = 1;
                        cnt     = 0;
                        curDly  = (delayQ.size() > 0) ? delayQ.pop_front() : 0;
                    end
                    memAck   = (cnt == curDly);
                    memRdata = (memAck && mem.exists(memAddr)) ? mem[memAddr] : $urandom;
                    cnt++;
                end else begin
                    inFetch  = 0;
                    memAck   = $urandom_range(0, 1) == 1;
                    memRdata = $urandom;
                end
            end else if (ackMode == 1) begin
                inFetch = 0;
                memAck  = 1'b0;
            end
        end
    end

    // Monitor: every EXEC cycle retires one predicted instruction.
    initial begin
        retire_t head;
        forever begin
            @(negedge clk);
            if (monEn) begin
                if (curState == 4'd1 && expQ.size() > 0) begin
                    checkOutput("fetch_addr", {16'd0, memAddr}, {16'd0, expQ[0].pc});
                    checkOutput("fetch_req", {31'd0, memReq}, 32'd1);
                    checkOutput("halted_clear_in_fetch", {31'd0, halted}, 32'd0);
                end else if (curState == 4'd2) begin
                    if (expQ.size() == 0) begin
                        checkOutput("unexpected_exec", {16'd0, pcOut}, 32'hFFFF_FFFF);
                    end else begin
                        head = expQ.pop_front();
                        checkOutput("exec_pc", {16'd0, pcOut}, {16'd0, head.pc});
                        checkOutput("exec_instr", instr0, head.word);
                        checkOutput("exec_req_low", {31'd0, memReq}, 32'd0);
                    end
                end
            end
        end
    end

    initial begin
        int fetchCycles;
        reset = 1'b1;
        repeat (3) @(negedge clk);
        checkOutput("rst_state", {28'd0, curState}, 32'd0);
        checkOutput("rst_pc", {16'd0, pcOut}, 32'd0);
        checkOutput("rst_instr", instr0, 32'd0);
        checkOutput("rst_req", {31'd0, memReq}, 32'd0);
        checkOutput("rst_addr", {16'd0, memAddr}, 32'd0);
        checkOutput("rst_flags", {30'd0, halted, fault}, 32'd0);
        reset     = 1'b0;
        autoDrive = 1;

        $display("[TB] zero-wait three-instruction program");
        mem.delete();
        mem[16'h0010] = 32'h0204_0005;
        mem[16'h0011] = 32'h0208_0007;
        mem[16'h0012] = 32'hFF00_0000;
        applyStimulus(16'h0010, 0, 0, 1, 0, 16'h0000);

        $display("[TB] three-cycle ack latency");
        applyStimulus(16'($urandom), 30, 3, 0, 0, 16'h0000);

        $display("[TB] taken jump and pc wrap");
        mem.delete();
        mem[16'h0020] = 32'h0100_0000;
        mem[16'h0100] = 32'hFF00_0001;
        applyStimulus(16'h0020, 0, 0, 1, 1, 16'h0100);
        mem.delete();
        mem[16'hFFFF] = 32'h0300_0000;
        mem[16'h0000] = 32'hFF00_0002;
        applyStimulus(16'hFFFF, 0, 1, 1, 0, 16'h0000);

        $display("[TB] memory timeout");
        monEn   = 0;
        ackMode = 1;
        launch(16'h1234);
        waitForState(4'd1, 10);
        fetchCycles = 0;
        for (int c = 0; c < 400; c++) begin
            if (curState != 4'd1) break;
            fetchCycles++;
            @(negedge clk);
        end
        checkOutput("timeout_fetch_cycles", fetchCycles, 255);
        checkOutput("timeout_state", {28'd0, curState}, 32'd15);
        checkOutput("timeout_fault", {31'd0, fault}, 32'd1);
        checkOutput("timeout_req", {31'd0, memReq}, 32'd0);
        checkOutput("timeout_pc", {16'd0, pcOut}, 32'h0000_1234);
        repeat (8) @(negedge clk);
        checkOutput("fault_sticky_state", {28'd0, curState}, 32'd15);
        checkOutput("fault_sticky_flag", {31'd0, fault}, 32'd1);
        doReset();
        checkOutput("fault_cleared", {31'd0, fault}, 32'd0);

        $display("[TB] ack in last permitted cycle");
        mem.delete();
        mem[16'h0200] = 32'hFF00_0003;
        applyStimulus(16'h0200, 0, 254, 1, 0, 16'h0000);

        $display("[TB] reset mid-fetch with simultaneous ack");
        monEn   = 0;
        ackMode = 2;
        memAck  = 1'b0;
        launch(16'h0040);
        waitForState(4'd1, 10);
        @(negedge clk);
        memAck   = 1'b1;
        memRdata = 32'hDEAD_BEEF;
        reset    = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        checkOutput("midrst_state", {28'd0, curState}, 32'd0);
        checkOutput("midrst_instr", instr0, 32'd0);
        checkOutput("midrst_pc_addr", {pcOut, memAddr}, 32'd0);
        checkOutput("midrst_req_flags", {29'd0, memReq, halted, fault}, 32'd0);
        @(negedge clk);
        memAck = 1'b0;
        checkOutput("post_rst_ack_state", {28'd0, curState}, 32'd0);
        checkOutput("post_rst_ack_instr", instr0, 32'd0);
        applyStimulus(16'($urandom), 30, -1, 0, 0, 16'h0000);

        $display("[TB] randomized programs");
        for (int i = 0; i < 25; i++) begin
            applyStimulus(16'($urandom), 35, -1, 0, 0, 16'h0000);
        end

        monEn     = 0;
        autoDrive = 0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fetch_control.md
FETCH_CONTROL -- requirements
Module: fetch_control

Interface
REQ-001 Parameter PC_WIDTH, default 16, width of program counter and memory address.
REQ-002 Parameter TIMEOUT, default 255, maximum FETCH cycles without mem_ack before fault.
REQ-003 Parameter HALT_OP, default 8'hFF, opcode (instr[31:24]) that stops execution.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 start  input  1  one-cycle pulse; begins execution at start_pc when idle.
REQ-007 start_pc  input  PC_WIDTH  entry address sampled with start.
REQ-008 mem_req  output  1  instruction-memory read request, registered.
REQ-009 mem_addr  output  PC_WIDTH  instruction address, registered.
REQ-010 mem_ack  input  1  memory response valid; qualifies mem_rdata.
REQ-011 mem_rdata  input  32  instruction word.
REQ-012 jump_en  input  1  branch taken, sampled in EXEC only.
REQ-013 jump_addr  input  PC_WIDTH  branch target, sampled with jump_en.
REQ-014 instr0  output  32  current instruction to the datapath, registered.
REQ-015 current_state  output  4  FSM state to the datapath, registered.
REQ-016 pc  output  PC_WIDTH  address of instr0.
REQ-017 halted  output  1  set when HALT_OP retired; cleared by start or reset.
REQ-018 fault  output  1  sticky memory-timeout indication.

Function
REQ-019 States/encodings: IDLE=4'd0, FETCH=4'd1, EXEC=4'd2, FAULT=4'd15; current_state always equals the state register.
REQ-020 IDLE: start=1 -> pc<=start_pc, mem_addr<=start_pc, mem_req<=1, halted<=0, next FETCH; else stay.
REQ-021 FETCH: mem_req=1, mem_addr=pc held stable until ack; mem_ack=1 -> instr0<=mem_rdata, mem_req<=0, wait counter<=0, next EXEC.
REQ-022 FETCH without mem_ack increments an 8-bit-or-wider wait counter; ack in the TIMEOUT-th FETCH cycle is accepted; no ack after TIMEOUT cycles -> FAULT.
REQ-023 EXEC lasts exactly one cycle; instr0 and pc stable throughout.
REQ-024 EXEC, instr0[31:24]==HALT_OP -> halted<=1, pc unchanged, next IDLE; jump_en ignored.
REQ-025 EXEC, otherwise: jump_en=1 -> pc<=jump_addr, else pc<=pc+1 modulo 2^PC_WIDTH (all-ones wraps to 0); mem_addr<=new pc, mem_req<=1, next FETCH.
REQ-026 Zero-wait memory (ack in first FETCH cycle) yields one instruction every 2 cycles.
REQ-027 FAULT: fault=1, mem_req=0, instr0 and pc frozen; exit only by reset.
REQ-028 start outside IDLE ignored; mem_ack outside FETCH ignored; jump_en outside EXEC ignored.
REQ-029 start and HALT_OP retirement never coincide in the same state; start in the IDLE cycle following halt restarts normally.

Reset
REQ-030 reset=1 at any edge, in any state including mid-FETCH, forces next state IDLE, current_state=0, instr0=0, pc=0, mem_addr=0, mem_req=0, halted=0, fault=0, wait counter=0; reset has priority over all inputs.
REQ-031 A memory ack arriving the cycle after reset is ignored.

Verification
REQ-032 start, start_pc=16'h0010, ack zero-wait with words 32'h02040005, 32'h02080007, 32'hFF000000 -> states 1,2,1,2,1,2,0; pc 0x10,0x11,0x12; halted=1 after third EXEC.
REQ-033 ack delayed 3 cycles per fetch -> mem_req held high 4 cycles with mem_addr constant; EXEC still exactly one cycle.
REQ-034 EXEC at pc=0x0020 with jump_en=1, jump_addr=0x0100 -> next mem_addr=0x0100; start_pc=0xFFFF, non-halt word -> next pc=0x0000.
REQ-035 No ack for 255 FETCH cycles -> current_state=15, fault=1, mem_req=0; ack on cycle 255 instead -> EXEC, no fault.
REQ-036 reset asserted on 2nd FETCH cycle with ack same cycle -> all outputs zero next cycle, instr0 not loaded; later start operates normally.
REQ-037 start pulsed during FETCH and EXEC, jump_en during FETCH -> no effect on pc or state sequence.
